// File: rtl/csa_pkg.sv
// csa_pkg: shared constants and types for the CSA digit feeder.
//   CSA_N     default operand width in bits
//   DIGIT_W   digit width (N/3) consumed by the CSA stages
//   HALF_W    half-digit width (N/6) used by downstream stages
//   BEATS     digit triples emitted per operand (fixed at 3)
//   beat_t    beat index type, state_t feeder FSM state
//   beat_next wrapping beat increment 0 -> 1 -> 2 -> 0
package csa_pkg;

  localparam int CSA_N   = 222;
  localparam int DIGIT_W = CSA_N / 3;
  localparam int HALF_W  = CSA_N / 6;
  localparam int BEATS   = 3;

  typedef logic [1:0] beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic beat_t beat_next(input beat_t b);
    return (b == beat_t'(BEATS - 1)) ? beat_t'(0) : b + beat_t'(1);
  endfunction

endpackage

// File: rtl/csa_digit_rot.sv
// csa_digit_rot: combinational digit rotator.
//   i_dig0..2  the three digits of the operand (digit[0..2])
//   i_beat     beat index 0..2
//   o_d1..3    rotated digits: d1=digit[k], d2=digit[k+1], d3=digit[k+2] (mod 3)
module csa_digit_rot #(
  parameter int DW = 74
) (
  input  logic [DW-1:0] i_dig0,
  input  logic [DW-1:0] i_dig1,
  input  logic [DW-1:0] i_dig2,
  input  logic [1:0]    i_beat,
  output logic [DW-1:0] o_d1,
  output logic [DW-1:0] o_d2,
  output logic [DW-1:0] o_d3
);

  always_comb begin
    o_d1 = i_dig0;
    o_d2 = i_dig1;
    o_d3 = i_dig2;
    case (i_beat)
      2'd1: begin
        o_d1 = i_dig1;
        o_d2 = i_dig2;
        o_d3 = i_dig0;
      end
      // Beat 3 never occurs; fold it onto beat 2 so the decode stays simple.
      2'd2, 2'd3: begin
        o_d1 = i_dig2;
        o_d2 = i_dig0;
        o_d3 = i_dig1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csa_digit_feeder.sv
// csa_digit_feeder: accepts one N-bit operand over valid/ready, splits it into
// three N/3-bit digits and emits three rotated digit triples with first/last
// framing and a seed-clear strobe for the downstream CSA accumulator.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   flush             synchronous abort of the operand in flight
//   in_valid/in_ready operand handshake (in_ready is combinational)
//   in_op             operand, digit[k] = in_op[k*N/3 +: N/3]
//   out_valid/ready   digit-triple handshake
//   d1, d2, d3        rotated digits (registered)
//   out_beat          beat index 0..2
//   out_first/last    framing, high on beat 0 / beat 2
//   seed_clr          high on beat 0, downstream clears its seed
//   out_par           per-digit even parity of {d3,d2,d1}
//
// Build option: CSA_FEEDER_PARITY_EN builds out_par; otherwise it is 3'b000.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no operand held, out_valid low
// SEND  | operand held, beats 0..2 being emitted
module csa_digit_feeder
  import csa_pkg::*;
#(
  parameter int N     = CSA_N,
  parameter int BEATS = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N/3-1:0] d1,
  output logic [N/3-1:0] d2,
  output logic [N/3-1:0] d3,
  output logic [1:0]     out_beat,
  output logic           out_first,
  output logic           out_last,
  output logic           seed_clr,
  output logic [2:0]     out_par
);

  localparam int DW = N / 3;

  if ((N % 6) != 0 || BEATS != 3) begin : g_bad_cfg
    $error("csa_digit_feeder: N must be divisible by 6 and BEATS must be 3");
  end

  state_t        r_state;
  beat_t         r_beat;
  logic [N-1:0]  r_op;
  logic          r_valid;
  logic          r_first;
  logic          r_last;
  logic [DW-1:0] r_d1;
  logic [DW-1:0] r_d2;
  logic [DW-1:0] r_d3;

  logic          w_acc;
  logic          w_adv;
  logic          w_load;
  logic          w_clear;
  logic [N-1:0]  w_src;
  beat_t         w_beat_nxt;
  logic [DW-1:0] w_d1;
  logic [DW-1:0] w_d2;
  logic [DW-1:0] w_d3;

  // A new operand may enter in the same cycle the last beat leaves.
  assign in_ready = !rst && !flush &&
                    (r_state == IDLE || (r_valid && out_ready && r_last));

  assign w_acc   = in_valid && in_ready;
  assign w_adv   = r_valid && out_ready;
  assign w_clear = flush || (w_adv && r_last && !w_acc);
  assign w_load  = w_acc || (w_adv && !r_last);

  // The rotator sees whichever operand and beat the registers load next, so
  // the data outputs depend on out_ready only through register enables.
  assign w_src      = w_acc ? in_op : r_op;
  assign w_beat_nxt = w_acc ? beat_t'(0) : beat_next(r_beat);

  csa_digit_rot #(.DW(DW)) u_rot (
    .i_dig0 (w_src[0*DW +: DW]),
    .i_dig1 (w_src[1*DW +: DW]),
    .i_dig2 (w_src[2*DW +: DW]),
    .i_beat (w_beat_nxt),
    .o_d1   (w_d1),
    .o_d2   (w_d2),
    .o_d3   (w_d3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
    end else if (w_clear) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
    end else if (w_load) begin
      r_state <= SEND;
      if (w_acc) begin
        r_op <= in_op;
      end
      r_beat  <= w_beat_nxt;
      r_valid <= 1'b1;
      r_first <= (w_beat_nxt == beat_t'(0));
      r_last  <= (w_beat_nxt == beat_t'(2));
      r_d1    <= w_d1;
      r_d2    <= w_d2;
      r_d3    <= w_d3;
    end
  end

`ifdef CSA_FEEDER_PARITY_EN
  logic [2:0] r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= '0;
    end else if (w_clear) begin
      r_par <= '0;
    end else if (w_load) begin
      r_par <= {^w_d3, ^w_d2, ^w_d1};
    end
  end

  assign out_par = r_par;
`else
  assign out_par = 3'b000;
`endif

  assign out_valid = r_valid;
  assign d1        = r_d1;
  assign d2        = r_d2;
  assign d3        = r_d3;
  assign out_beat  = r_beat;
  assign out_first = r_first;
  assign out_last  = r_last;
  assign seed_clr  = r_first;

endmodule
